gin_cfg_ctrl: RTL and testbench

//  Configuration sequencer for one GIN bus (row of multicast controllers).

---
 rtl/gin_cfg_ctrl_if.sv | 39 +++
 rtl/gin_cfg_ctrl.sv | 93 +++++++++
 tb/tb_gin_cfg_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/gin_cfg_ctrl_if.sv
// Signal bundle between the GIN config sequencer, its upstream/config sources
// and the GIN bus; "master" is the sequencer side, "slave" the environment side.
interface gin_cfg_ctrl_if #(
    parameter int ID_SIZE   = 5,
    parameter int DATA_BITS = 64
);
    logic                 cfg_start;
    logic                 id_valid;
    logic [ID_SIZE-1:0]   id_data;
    logic                 id_ready;
    logic [ID_SIZE-1:0]   up_tag;
    logic                 up_valid;
    logic [DATA_BITS-1:0] up_data;
    logic                 up_ready;
    logic [ID_SIZE-1:0]   tag;
    logic                 master_valid;
    logic [DATA_BITS-1:0] master_data;
    logic                 master_ready;
    logic                 set_id;
    logic [ID_SIZE-1:0]   ID_scan_in;
    logic [ID_SIZE-1:0]   ID_scan_out;
    logic                 busy;
    logic                 cfg_done;
    logic                 cfg_err;

    modport master (
        input  cfg_start, id_valid, id_data, up_tag, up_valid, up_data,
               master_ready, ID_scan_out,
        output id_ready, up_ready, tag, master_valid, master_data,
               set_id, ID_scan_in, busy, cfg_done, cfg_err
    );

    modport slave (
        output cfg_start, id_valid, id_data, up_tag, up_valid, up_data,
               master_ready, ID_scan_out,
        input  id_ready, up_ready, tag, master_valid, master_data,
               set_id, ID_scan_in, busy, cfg_done, cfg_err
    );
endinterface

// File: rtl/gin_cfg_ctrl.sv
// GIN bus configuration sequencer: drains the master stream, shifts column IDs
// into the MC scan chain, verifies the chain tail and reopens the bus.
module gin_cfg_ctrl #(
    parameter int NUMS_SLAVE = 6,
    parameter int ID_SIZE    = 5,
    parameter int DATA_BITS  = 64
) (
    input  logic          clk,
    input  logic          rst,
    gin_cfg_ctrl_if.master bus
);
    localparam int CW = $clog2(NUMS_SLAVE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ID_SIZE-1:0] first_id_q, first_id_d;
    logic               cfg_err_q, cfg_err_d;

    assign bus.tag         = bus.up_tag;
    assign bus.master_data = bus.up_data;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cfg_err     = cfg_err_q;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        first_id_d       = first_id_q;
        cfg_err_d        = cfg_err_q;
        bus.master_valid = 1'b0;
        bus.up_ready     = 1'b0;
        bus.id_ready     = 1'b0;
        bus.set_id       = 1'b0;
        bus.ID_scan_in   = '0;
        bus.cfg_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.master_valid = bus.up_valid;
                bus.up_ready     = bus.master_ready;
                if (bus.cfg_start) begin
                    state_d   = S_DRAIN;
                    cfg_err_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_DRAIN: begin
                // Keep the bus open so a presented beat completes its handshake.
                bus.master_valid = bus.up_valid;
                bus.up_ready     = bus.master_ready;
                if (!bus.up_valid || bus.master_ready)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                bus.id_ready = 1'b1;
                if (bus.id_valid) begin
                    bus.set_id     = 1'b1;
                    bus.ID_scan_in = bus.id_data;
                    cnt_d          = cnt_q + CW'(1);
                    if (cnt_q == '0)
                        first_id_d = bus.id_data;
                    if (cnt_q == CW'(NUMS_SLAVE - 1))
                        state_d = S_CHECK;
                end
            end
            default: begin
                // The first ID shifted in must have reached the chain tail.
                if (bus.ID_scan_out == first_id_q)
                    bus.cfg_done = 1'b1;
                else
                    cfg_err_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            first_id_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_id_q <= first_id_d;
            cfg_err_q  <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_gin_cfg_ctrl.sv
// Directed bench for gin_cfg_ctrl with a behavioural six-stage MC scan chain.
module tb_gin_cfg_ctrl;
    localparam int NS = 6;
    localparam int IW = 5;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   nset  = 0;
    int   base;
    bit   drop_req = 1'b0;
    int   drop_at  = 0;
    logic [IW-1:0] chain [NS];

    gin_cfg_ctrl_if #(.ID_SIZE(IW), .DATA_BITS(DW)) bus ();

    gin_cfg_ctrl #(.NUMS_SLAVE(NS), .ID_SIZE(IW), .DATA_BITS(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Scan chain model; can skip one shift to emulate a lost set_id.
    always @(posedge clk) begin
        if (bus.set_id) begin
            nset <= nset + 1;
            if (!(drop_req && nset == drop_at)) begin
                chain[0] <= bus.ID_scan_in;
                for (int i = 1; i < NS; i++) chain[i] <= chain[i-1];
            end
        end
    end
    assign bus.ID_scan_out = chain[NS-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // cfg_start in IDLE with upstream idle; returns positioned in the first LOAD cycle.
    task automatic start_cfg();
        bus.cfg_start = 1'b1;
        settle();
        chk("start_busy0", bus.busy, 0);
        tick();
        bus.cfg_start = 1'b0;
        settle();
        chk("drain_busy", bus.busy, 1);
        chk("drain_err_clr", bus.cfg_err, 0);
        chk("drain_no_set", bus.set_id, 0);
        tick();
    endtask

    // Shift IDs 5..0; optional gaps between beats and a cfg_start pulse mid-load.
    task automatic load_ids(input bit gaps, input bit poke);
        for (int k = 0; k < NS; k++) begin
            bus.id_valid  = 1'b1;
            bus.id_data   = IW'(NS - 1 - k);
            bus.cfg_start = poke && (k == 2);
            settle();
            chk("load_set", bus.set_id, 1);
            chk("load_scan", bus.ID_scan_in, NS - 1 - k);
            chk("load_gate_v", bus.master_valid, 0);
            chk("load_gate_r", bus.up_ready, 0);
            tick();
            bus.cfg_start = 1'b0;
            if (gaps && k < NS - 1) begin
                bus.id_valid = 1'b0;
                settle();
                chk("gap_rdy", bus.id_ready, 1);
                chk("gap_set", bus.set_id, 0);
                chk("gap_scan", bus.ID_scan_in, 0);
                tick();
            end
        end
        bus.id_valid = 1'b0;
    endtask

    task automatic check_phase(input bit ok);
        settle();
        chk("chk_done", bus.cfg_done, ok);
        chk("chk_busy", bus.busy, 1);
        chk("chk_rdy", bus.id_ready, 0);
        tick();
        chk("end_busy", bus.busy, 0);
        chk("end_done", bus.cfg_done, 0);
        chk("end_err", bus.cfg_err, !ok);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) chain[i] = '0;
        bus.cfg_start    = 1'b0;
        bus.id_valid     = 1'b0;
        bus.id_data      = '0;
        bus.up_tag       = '0;
        bus.up_valid     = 1'b0;
        bus.up_data      = '0;
        bus.master_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and IDLE pass-through.
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.cfg_err, 0);
        chk("rst_done", bus.cfg_done, 0);
        chk("rst_rdy", bus.id_ready, 0);
        chk("rst_set", bus.set_id, 0);
        chk("rst_scan", bus.ID_scan_in, 0);
        bus.up_valid = 1'b1; bus.master_ready = 1'b0;
        bus.up_tag = 5'd7; bus.up_data = 64'hDEAD_BEEF_0123_4567;
        settle();
        chk("pt_valid", bus.master_valid, 1);
        chk("pt_ready", bus.up_ready, 0);
        chk("pt_tag", bus.tag, 7);
        chk("pt_data", bus.master_data, 64'hDEAD_BEEF_0123_4567);
        bus.up_valid = 1'b0; bus.master_ready = 1'b1;
        tick();

        // 1: idle bus, back-to-back IDs; id_valid early must not shift in IDLE/DRAIN.
        base = nset;
        bus.id_valid = 1'b1;
        settle();
        chk("idle_noset", bus.set_id, 0);
        chk("idle_nordy", bus.id_ready, 0);
        start_cfg();
        bus.up_valid = 1'b1;
        load_ids(1'b0, 1'b0);
        bus.up_valid = 1'b0;
        chk("t1_tail", bus.ID_scan_out, 5);
        check_phase(1'b1);
        chk("t1_pulses", nset - base, 6);

        // 2: held upstream beat stalls DRAIN until its handshake.
        base = nset;
        bus.up_valid = 1'b1; bus.master_ready = 1'b0; bus.up_data = 64'h55;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t2_hold_v", bus.master_valid, 1);
            chk("t2_hold_r", bus.up_ready, 0);
            chk("t2_hold_load", bus.id_ready, 0);
            tick();
        end
        bus.master_ready = 1'b1;
        settle();
        chk("t2_hs_v", bus.master_valid, 1);
        chk("t2_hs_r", bus.up_ready, 1);
        tick();
        bus.up_data = 64'h66;
        settle();
        chk("t2_load_r", bus.up_ready, 0);
        chk("t2_load_v", bus.master_valid, 0);
        chk("t2_load_rdy", bus.id_ready, 1);
        load_ids(1'b0, 1'b0);
        bus.up_valid = 1'b0;
        check_phase(1'b1);
        chk("t2_pulses", nset - base, 6);

        // 3: id_valid toggling each cycle.
        base = nset;
        start_cfg();
        load_ids(1'b1, 1'b0);
        check_phase(1'b1);
        chk("t3_pulses", nset - base, 6);

        // 4: lost shift -> tail mismatch, sticky error cleared by next start.
        drop_at = nset; drop_req = 1'b1;
        start_cfg();
        load_ids(1'b0, 1'b0);
        drop_req = 1'b0;
        check_phase(1'b0);
        tick();
        chk("t4_sticky", bus.cfg_err, 1);
        start_cfg();
        load_ids(1'b0, 1'b0);
        check_phase(1'b1);

        // 5: reset mid-LOAD after three IDs.
        start_cfg();
        for (int k = 0; k < 3; k++) begin
            bus.id_valid = 1'b1; bus.id_data = IW'(5 - k);
            tick();
        end
        rst = 1'b1;
        tick();
        bus.up_valid = 1'b1; bus.master_ready = 1'b1;
        settle();
        chk("t5_busy", bus.busy, 0);
        chk("t5_set", bus.set_id, 0);
        chk("t5_rdy", bus.id_ready, 0);
        chk("t5_scan", bus.ID_scan_in, 0);
        chk("t5_pt_v", bus.master_valid, 1);
        chk("t5_pt_r", bus.up_ready, 1);
        rst = 1'b0; bus.id_valid = 1'b0; bus.up_valid = 1'b0;
        tick();
        base = nset;
        start_cfg();
        load_ids(1'b0, 1'b0);
        check_phase(1'b1);
        chk("t5_pulses", nset - base, 6);

        // 6: cfg_start during LOAD is ignored.
        base = nset;
        start_cfg();
        load_ids(1'b0, 1'b1);
        check_phase(1'b1);
        tick();
        chk("t6_idle", bus.busy, 0);
        chk("t6_pulses", nset - base, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
